// File: rtl/fft_bfly_sched_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT butterfly sequencer.
// bfly_addr works at the widest supported size; callers truncate to their LOG2N.
package fft_pkg;

  localparam int LOG2N_DEF  = 6;
  localparam int RD_LAT_DEF = 1;
  localparam int BF_LAT_DEF = 2;
  localparam int ADDR_MAXW  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_MAXW-1:0] ia;
    logic [ADDR_MAXW-1:0] ib;
    logic [ADDR_MAXW-1:0] tw;
  } bfly_t;

  // Cycles from a read strobe to the matching write strobe.
  function automatic int lat_of(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction

  // Butterfly k of stage s: the top operand keeps bit s clear, the bottom one sets it.
  function automatic bfly_t bfly_addr(input logic [ADDR_MAXW-1:0] k,
                                      input logic [3:0]           s,
                                      input logic [3:0]           log2n);
    logic [ADDR_MAXW-1:0] span_m;
    bfly_t                r;
    span_m = (10'd1 << s) - 10'd1;
    r.ia   = ((k >> s) << (s + 4'd1)) | (k & span_m);
    r.ib   = r.ia + span_m + 10'd1;
    r.tw   = (k & span_m) << (log2n - 4'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift register carrying the write-back strobe and addresses.
// It shifts every cycle, so stalls upstream appear as bubbles downstream.
module fft_wb_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// Sequencer for an in-place radix-2 DIT FFT: issues one butterfly read per cycle,
// drains the pipeline between stages and issues the matching write-back LAT cycles later.
module fft_bfly_sched
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [3:0]       stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int AW  = LOG2N;
  localparam int TW  = LOG2N - 1;
  localparam int KW  = LOG2N - 1;
  localparam int LAT = lat_of(RD_LAT, BF_LAT);
  localparam int DW  = $clog2(LAT + 1);

  // Handshake: rd_en marks a valid read of rd_addr_a/rd_addr_b/tw_addr in the same
  // cycle; wr_en marks a valid write of x/y to wr_addr_a/wr_addr_b. No back-pressure.
  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [3:0]      s_q, s_d;
  logic [DW-1:0]   dr_q, dr_d;
  logic [AW-1:0]   ia_q, ib_q;
  logic [TW-1:0]   tw_q;
  bfly_t           ba;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    dr_d    = dr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        if (!hold) begin
          if (k_q == '1) begin
            state_d = DRAIN;
            dr_d    = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DRAIN: begin
        // The last write of the stage lands in the final drain cycle.
        if (dr_q == DW'(LAT - 1)) begin
          if (s_q != 4'(LOG2N - 1)) begin
            state_d = RUN;
            s_d     = s_q + 4'd1;
            k_d     = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          dr_d = dr_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ba = bfly_addr(ADDR_MAXW'(k_d), s_d, 4'(LOG2N));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      dr_q    <= '0;
      ia_q    <= '0;
      ib_q    <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      dr_q    <= dr_d;
      // Addresses are precomputed for the butterfly that will be presented next cycle.
      if (state_d == RUN) begin
        ia_q <= AW'(ba.ia);
        ib_q <= AW'(ba.ib);
        tw_q <= TW'(ba.tw);
      end else begin
        ia_q <= '0;
        ib_q <= '0;
        tw_q <= '0;
      end
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign stage     = s_q;
  assign rd_en     = (state_q == RUN) && !hold;
  assign rd_addr_a = ia_q;
  assign rd_addr_b = ib_q;
  assign tw_addr   = tw_q;

  fft_wb_delay #(
    .DEPTH(LAT),
    .WIDTH(1 + 2 * AW)
  ) u_wb_delay (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   ({rd_en, rd_addr_a, rd_addr_b}),
    .q_o   ({wr_en, wr_addr_a, wr_addr_b})
  );

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched: four sizes, directed and random hold patterns, checked
// cycle by cycle against a timeline built from the FFT's group/offset loop structure.
module tb_fft_bfly_sched;

  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic       hold;
  int         sel;
  int         n_checks = 0;
  int         n_err    = 0;

  always #5 clk = ~clk;

  logic u3_busy, u3_done, u3_rd, u3_wr;
  logic [3:0] u3_stage;
  logic [2:0] u3_ra, u3_rb, u3_wa, u3_wb;
  logic [1:0] u3_tw;
  logic u2_busy, u2_done, u2_rd, u2_wr;
  logic [3:0] u2_stage;
  logic [1:0] u2_ra, u2_rb, u2_wa, u2_wb;
  logic [0:0] u2_tw;
  logic u6_busy, u6_done, u6_rd, u6_wr;
  logic [3:0] u6_stage;
  logic [5:0] u6_ra, u6_rb, u6_wa, u6_wb;
  logic [4:0] u6_tw;
  logic u10_busy, u10_done, u10_rd, u10_wr;
  logic [3:0] u10_stage;
  logic [9:0] u10_ra, u10_rb, u10_wa, u10_wb;
  logic [8:0] u10_tw;

  fft_bfly_sched #(.LOG2N(3), .RD_LAT(1), .BF_LAT(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .hold(hold),
    .busy(u3_busy), .done(u3_done), .stage(u3_stage),
    .rd_en(u3_rd), .rd_addr_a(u3_ra), .rd_addr_b(u3_rb), .tw_addr(u3_tw),
    .wr_en(u3_wr), .wr_addr_a(u3_wa), .wr_addr_b(u3_wb));

  fft_bfly_sched #(.LOG2N(2), .RD_LAT(2), .BF_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .hold(hold),
    .busy(u2_busy), .done(u2_done), .stage(u2_stage),
    .rd_en(u2_rd), .rd_addr_a(u2_ra), .rd_addr_b(u2_rb), .tw_addr(u2_tw),
    .wr_en(u2_wr), .wr_addr_a(u2_wa), .wr_addr_b(u2_wb));

  fft_bfly_sched #(.LOG2N(6), .RD_LAT(2), .BF_LAT(3)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .hold(hold),
    .busy(u6_busy), .done(u6_done), .stage(u6_stage),
    .rd_en(u6_rd), .rd_addr_a(u6_ra), .rd_addr_b(u6_rb), .tw_addr(u6_tw),
    .wr_en(u6_wr), .wr_addr_a(u6_wa), .wr_addr_b(u6_wb));

  fft_bfly_sched #(.LOG2N(10), .RD_LAT(2), .BF_LAT(3)) u10 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .hold(hold),
    .busy(u10_busy), .done(u10_done), .stage(u10_stage),
    .rd_en(u10_rd), .rd_addr_a(u10_ra), .rd_addr_b(u10_rb), .tw_addr(u10_tw),
    .wr_en(u10_wr), .wr_addr_a(u10_wa), .wr_addr_b(u10_wb));

  logic [57:0] pk [4];
  assign pk[0] = {u3_busy, u3_done, u3_rd, u3_wr, u3_stage, 10'(u3_ra), 10'(u3_rb),
                  10'(u3_tw), 10'(u3_wa), 10'(u3_wb)};
  assign pk[1] = {u2_busy, u2_done, u2_rd, u2_wr, u2_stage, 10'(u2_ra), 10'(u2_rb),
                  10'(u2_tw), 10'(u2_wa), 10'(u2_wb)};
  assign pk[2] = {u6_busy, u6_done, u6_rd, u6_wr, u6_stage, 10'(u6_ra), 10'(u6_rb),
                  10'(u6_tw), 10'(u6_wa), 10'(u6_wb)};
  assign pk[3] = {u10_busy, u10_done, u10_rd, u10_wr, u10_stage, 10'(u10_ra), 10'(u10_rb),
                  10'(u10_tw), 10'(u10_wa), 10'(u10_wb)};

  logic       o_busy, o_done, o_rd, o_wr;
  logic [3:0] o_stage;
  logic [9:0] o_ra, o_rb, o_tw, o_wa, o_wb;
  assign {o_busy, o_done, o_rd, o_wr, o_stage, o_ra, o_rb, o_tw, o_wa, o_wb} = pk[sel];

  // Expected timeline, indexed by cycle with cycle 0 = the cycle start is driven.
  bit e_busy[MAXC], e_done[MAXC], e_rd[MAXC], e_wr[MAXC], e_first[MAXC], e_zero[MAXC];
  bit hold_arr[MAXC], start_arr[MAXC];
  int e_ra[MAXC], e_rb[MAXC], e_tw[MAXC], e_wa[MAXC], e_wb[MAXC], e_stage[MAXC];

  // Pending write-backs {addr_a, addr_b}, in issue order.
  logic [19:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rd_en"}, o_rd, 0);
    chk({tag, "_wr_en"}, o_wr, 0);
    chk({tag, "_stage"}, o_stage, 0);
    chk({tag, "_rd_addr_a"}, o_ra, 0);
    chk({tag, "_rd_addr_b"}, o_rb, 0);
    chk({tag, "_tw_addr"}, o_tw, 0);
    chk({tag, "_wr_addr_a"}, o_wa, 0);
    chk({tag, "_wr_addr_b"}, o_wb, 0);
  endtask

  task automatic run(input int which, input int l2n, input int lat,
                     input int hold_lo, input int hold_hi, input int pct,
                     input int abort_t, input bit restart,
                     output int busy_cnt, output int exp_busy,
                     output int done_at, output int done_n);
    int          n2, t, end_t, done_t;
    bit          hit;
    logic [19:0] exp_w;
    n2 = (1 << l2n) / 2;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_first[i] = 0;
      e_zero[i] = 0; e_ra[i] = 0; e_rb[i] = 0; e_tw[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
      e_stage[i] = 0; start_arr[i] = 0;
      hold_arr[i] = ((pct > 0) && ($urandom_range(0, 99) < pct)) || (i >= hold_lo && i <= hold_hi);
    end
    // Stage s splits the array into groups of 2*span; butterfly j of a group pairs
    // j with j+span and uses twiddle j*N/(2*span).
    t = 1;
    for (int s = 0; s < l2n; s++) begin
      for (int g = 0; g < (n2 >> s); g++) begin
        for (int j = 0; j < (1 << s); j++) begin
          while (hold_arr[t]) begin
            e_busy[t] = 1; e_stage[t] = s; t++;
          end
          e_busy[t]  = 1; e_stage[t] = s; e_rd[t] = 1;
          e_ra[t]    = g * 2 * (1 << s) + j;
          e_rb[t]    = e_ra[t] + (1 << s);
          e_tw[t]    = j * (n2 >> s);
          e_first[t] = (g == 0) && (j == 0);
          t++;
        end
      end
      for (int d = 0; d < lat; d++) begin
        e_busy[t] = 1; e_stage[t] = s; t++;
      end
    end
    e_done[t] = 1; e_stage[t] = l2n - 1; done_t = t;
    for (int i = lat; i < MAXC; i++) begin
      e_wr[i] = e_rd[i-lat]; e_wa[i] = e_ra[i-lat]; e_wb[i] = e_rb[i-lat];
    end
    end_t = (abort_t >= 0) ? abort_t + lat + 3 : done_t + lat + 3;
    if (abort_t >= 0) begin
      for (int i = abort_t + 1; i < MAXC; i++) begin
        e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_first[i] = 0;
        e_ra[i] = 0; e_rb[i] = 0; e_tw[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
        e_stage[i] = 0; e_zero[i] = 1;
      end
    end
    exp_busy = 0;
    for (int i = 0; i < MAXC; i++) exp_busy += int'(e_busy[i]);
    start_arr[0] = 1;
    if (restart) begin
      start_arr[3] = 1; start_arr[done_t] = 1;
    end

    sel = which; busy_cnt = 0; done_at = -1; done_n = 0;
    exp_q.delete();
    for (int c = 0; c <= end_t; c++) begin
      @(posedge clk); #1;
      start_v = start_arr[c] ? (4'b0001 << which) : 4'b0000;
      hold    = hold_arr[c];
      rst_n   = !((abort_t >= 0) && (c == abort_t));
      @(negedge clk);
      chk("busy", o_busy, e_busy[c]);
      chk("done", o_done, e_done[c]);
      chk("rd_en", o_rd, e_rd[c]);
      chk("wr_en", o_wr, e_wr[c]);
      if (e_rd[c]) begin
        chk("rd_addr_a", o_ra, e_ra[c]);
        chk("rd_addr_b", o_rb, e_rb[c]);
        chk("tw_addr", o_tw, e_tw[c]);
      end
      if (e_wr[c]) begin
        chk("wr_addr_a", o_wa, e_wa[c]);
        chk("wr_addr_b", o_wb, e_wb[c]);
      end
      if (e_busy[c] || e_done[c] || e_zero[c]) chk("stage", o_stage, e_stage[c]);
      if (e_zero[c]) begin
        chk("rst_rd_addr_a", o_ra, 0); chk("rst_rd_addr_b", o_rb, 0); chk("rst_tw_addr", o_tw, 0);
        chk("rst_wr_addr_a", o_wa, 0); chk("rst_wr_addr_b", o_wb, 0);
      end
      if (o_rd && e_first[c]) begin
        hit = 0;
        foreach (exp_q[i]) if (exp_q[i][19:10] == o_ra || exp_q[i][9:0] == o_ra ||
                               exp_q[i][19:10] == o_rb || exp_q[i][9:0] == o_rb) hit = 1;
        chk("raw_hazard", hit, 0);
      end
      if (o_wr) begin
        chk("wb_has_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("wb_order", {o_wa, o_wb}, exp_w);
        end
      end
      if (o_rd) exp_q.push_back({o_ra, o_rb});
      if ((abort_t >= 0) && (c == abort_t)) exp_q.delete();
      busy_cnt += int'(o_busy);
      if (o_done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
    end
  endtask

  initial begin
    int bc, eb, da, dn;
    rst_n = 1'b0; start_v = 4'b1111; hold = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1; chk_idle("reset");
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start_v = 4'b0000;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1; chk_idle("start_in_reset");
    end

    run(0, 3, 3, -1, -2, 0, -1, 0, bc, eb, da, dn);
    chk("t1_busy_len", bc, 21); chk("t1_done_at", da, 22); chk("t1_done_n", dn, 1);

    run(0, 3, 3, 2, 3, 0, -1, 0, bc, eb, da, dn);
    chk("t3_busy_len", bc, 23); chk("t3_done_at", da, 24); chk("t3_done_n", dn, 1);

    run(0, 3, 3, -1, -2, 0, 13, 0, bc, eb, da, dn);
    chk("t4_busy_len", bc, 13); chk("t4_done_n", dn, 0);
    run(0, 3, 3, -1, -2, 0, -1, 0, bc, eb, da, dn);
    chk("t4_rerun_busy_len", bc, 21); chk("t4_rerun_done_at", da, 22);

    run(0, 3, 3, -1, -2, 0, -1, 1, bc, eb, da, dn);
    chk("t5_busy_len", bc, 21); chk("t5_done_at", da, 22); chk("t5_done_n", dn, 1);

    for (int r = 0; r < 3; r++) begin
      run(0, 3, 3, -1, -2, 30, -1, 0, bc, eb, da, dn);
      chk("rand3_busy_len", bc, eb); chk("rand3_done_n", dn, 1);
    end

    run(1, 2, 5, -1, -2, 0, -1, 0, bc, eb, da, dn);
    chk("n4_busy_len", bc, 2 * (2 + 5)); chk("n4_done_n", dn, 1);
    run(1, 2, 5, -1, -2, 30, -1, 0, bc, eb, da, dn);
    chk("n4_rand_busy_len", bc, eb);

    run(2, 6, 5, -1, -2, 25, -1, 0, bc, eb, da, dn);
    chk("n64_rand_busy_len", bc, eb); chk("n64_done_n", dn, 1);

    run(3, 10, 5, -1, -2, 0, -1, 0, bc, eb, da, dn);
    chk("n1024_busy_len", bc, 10 * (512 + 5)); chk("n1024_done_n", dn, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
